// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: set-2 scan codes, the game-key map and the frame FSM states.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rxState_e;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam int NUM_KEYS = 8;

    // {ext, code} per key, in output order p1 up/down/left/right then p2 up/down/left/right.
    localparam logic [8:0] KEY_MAP [NUM_KEYS] = '{
        {1'b0, SC_W},  {1'b0, SC_S},    {1'b0, SC_A},    {1'b0, SC_D},
        {1'b1, SC_UP}, {1'b1, SC_DOWN}, {1'b1, SC_LEFT}, {1'b1, SC_RIGHT}
    };

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receiver: line synchroniser, clock glitch filter, 11-bit frame FSM and mid-frame timeout.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [7:0] rxByte,
    output logic       byteValid,
    output logic       err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clkSyncReg;
    logic [SYNC_STAGES-1:0] dataSyncReg;
    logic                   clkS;
    logic                   dataS;
    logic                   filtLevelReg;
    logic [FW-1:0]          filtCntReg;
    logic                   fallEn;

    rxState_e      stateReg, stateNext;
    logic [2:0]    bitCntReg, bitCntNext;
    logic [7:0]    shiftReg, shiftNext;
    logic          parityReg, parityNext;
    logic [TW-1:0] timeoutReg, timeoutNext;

    assign clkS  = clkSyncReg[SYNC_STAGES-1];
    assign dataS = dataSyncReg[SYNC_STAGES-1];

    // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
    assign fallEn = filtLevelReg && !clkS && (filtCntReg == FW'(FILTER_LEN - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clkSyncReg   <= '1;
            dataSyncReg  <= '1;
            filtLevelReg <= 1'b1;
            filtCntReg   <= '0;
        end else begin
            clkSyncReg  <= {clkSyncReg[SYNC_STAGES-2:0], ps2Clk};
            dataSyncReg <= {dataSyncReg[SYNC_STAGES-2:0], ps2Data};
            if (clkS == filtLevelReg) begin
                filtCntReg <= '0;
            end else if (filtCntReg == FW'(FILTER_LEN - 1)) begin
                filtLevelReg <= clkS;
                filtCntReg   <= '0;
            end else begin
                filtCntReg <= filtCntReg + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg   <= IDLE;
            bitCntReg  <= '0;
            shiftReg   <= '0;
            parityReg  <= 1'b0;
            timeoutReg <= '0;
        end else begin
            stateReg   <= stateNext;
            bitCntReg  <= bitCntNext;
            shiftReg   <= shiftNext;
            parityReg  <= parityNext;
            timeoutReg <= timeoutNext;
        end
    end

    always_comb begin
        stateNext   = stateReg;
        bitCntNext  = bitCntReg;
        shiftNext   = shiftReg;
        parityNext  = parityReg;
        byteValid   = 1'b0;
        err         = 1'b0;
        timeoutNext = (stateReg == IDLE || fallEn) ? '0 : timeoutReg + TW'(1);

        if (fallEn) begin
            case (stateReg)
                IDLE: begin
                    if (!dataS) begin
                        stateNext  = DATA;
                        bitCntNext = '0;
                    end
                end
                DATA: begin
                    shiftNext  = {dataS, shiftReg[7:1]};
                    bitCntNext = bitCntReg + 3'd1;
                    if (bitCntReg == 3'd7) stateNext = PARITY;
                end
                PARITY: begin
                    parityNext = dataS;
                    stateNext  = STOP;
                end
                STOP: begin
                    stateNext = IDLE;
                    if (dataS && (^{shiftReg, parityReg})) byteValid = 1'b1;
                    else                                   err       = 1'b1;
                end
                default: stateNext = IDLE;
            endcase
        end else if (stateReg != IDLE && timeoutReg == TW'(TIMEOUT_CYCLES)) begin
            stateNext   = IDLE;
            err         = 1'b1;
            timeoutNext = '0;
        end
    end

    assign rxByte = shiftReg;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard decoder: tracks E0/F0 prefixes and holds eight game-key levels.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p1_left,
    output logic       p1_right,
    output logic       p2_up,
    output logic       p2_down,
    output logic       p2_left,
    output logic       p2_right,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    logic [7:0]          rxByte;
    logic                byteValid;
    logic                rxErr;
    logic                extReg;
    logic                brkReg;
    logic [NUM_KEYS-1:0] keyReg;

    ps2_rx_frame #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .ps2Clk   (ps2_clk),
        .ps2Data  (ps2_data),
        .rxByte   (rxByte),
        .byteValid(byteValid),
        .err      (rxErr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_valid <= 1'b0;
            scan_code  <= '0;
            frame_err  <= 1'b0;
            extReg     <= 1'b0;
            brkReg     <= 1'b0;
        end else begin
            scan_valid <= byteValid;
            frame_err  <= rxErr;
            if (byteValid) scan_code <= rxByte;
            if (rxErr) begin
                extReg <= 1'b0;
                brkReg <= 1'b0;
            end else if (byteValid) begin
                if (rxByte == SC_EXT) begin
                    extReg <= 1'b1;
                end else if (rxByte == SC_BRK) begin
                    brkReg <= 1'b1;
                end else begin
                    extReg <= 1'b0;
                    brkReg <= 1'b0;
                end
            end
        end
    end

    // Prefix bytes never appear in KEY_MAP, so a plain {ext, byte} match is sufficient.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    keyReg[gi] <= 1'b0;
                end else if (byteValid && ({extReg, rxByte} == KEY_MAP[gi])) begin
                    keyReg[gi] <= ~brkReg;
                end
            end
        end
    endgenerate

    assign p1_up    = keyReg[0];
    assign p1_down  = keyReg[1];
    assign p1_left  = keyReg[2];
    assign p1_right = keyReg[3];
    assign p2_up    = keyReg[4];
    assign p2_down  = keyReg[5];
    assign p2_left  = keyReg[6];
    assign p2_right = keyReg[7];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames with hand-computed expectations.
module tb_ps2_key_decoder;

    localparam int HALF = 30;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       p1_up, p1_down, p1_left, p1_right;
    logic       p2_up, p2_down, p2_left, p2_right;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int validCnt = 0;
    int errCnt = 0;
    int errCyc = 0;
    int lastFall = 0;
    logic [7:0] keysAtValid = '0;
    logic [7:0] keys;

    ps2_key_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .p1_up     (p1_up),
        .p1_down   (p1_down),
        .p1_left   (p1_left),
        .p1_right  (p1_right),
        .p2_up     (p2_up),
        .p2_down   (p2_down),
        .p2_left   (p2_left),
        .p2_right  (p2_right),
        .scan_valid(scan_valid),
        .scan_code (scan_code),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    assign keys = {p2_right, p2_left, p2_down, p2_up, p1_right, p1_left, p1_down, p1_up};

    always @(negedge clk) begin
        cyc++;
        if (scan_valid) begin
            validCnt++;
            keysAtValid = keys;
        end
        if (frame_err) begin
            errCnt++;
            errCyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        lastFall = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flipPar, input logic stopBit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b) ^ flipPar);
        send_bit(stopBit);
        ps2_data = 1'b1;
        repeat (3 * HALF) @(negedge clk);
        $display("frame %02h flipPar=%0d stop=%0d -> code=%02h keys=%02h", b, flipPar, stopBit, scan_code, keys);
    endtask

    initial begin
        int v0;
        int e0;
        int delta;

        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_keys", 32'(keys), 32'h00);
        check("rst_valid", 32'(scan_valid), 32'h0);
        check("rst_code", 32'(scan_code), 32'h00);
        check("rst_err", 32'(frame_err), 32'h0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // W make, then break across F0 / 1D.
        v0 = validCnt;
        send_frame(8'h1D, 1'b0, 1'b1);
        check("w_pulse", 32'(validCnt - v0), 32'd1);
        check("w_code", 32'(scan_code), 32'h1D);
        check("w_keys", 32'(keys), 32'h01);
        check("w_latency", 32'(keysAtValid), 32'h01);
        send_frame(8'hF0, 1'b0, 1'b1);
        check("f0_hold", 32'(keys), 32'h01);
        check("f0_code", 32'(scan_code), 32'hF0);
        send_frame(8'h1D, 1'b0, 1'b1);
        check("w_break", 32'(keys), 32'h00);

        // Extended up arrow, keypad 8 ignored, extended break.
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        check("up_make", 32'(keys), 32'h10);
        send_frame(8'h75, 1'b0, 1'b1);
        check("kp8_keys", 32'(keys), 32'h10);
        check("kp8_code", 32'(scan_code), 32'h75);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        check("up_break", 32'(keys), 32'h00);

        // Parity error.
        v0 = validCnt;
        e0 = errCnt;
        send_frame(8'h1C, 1'b1, 1'b1);
        check("par_err", 32'(errCnt - e0), 32'd1);
        check("par_novalid", 32'(validCnt - v0), 32'd0);
        check("par_keys", 32'(keys), 32'h00);
        check("par_code", 32'(scan_code), 32'h75);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("a_make", 32'(keys), 32'h04);

        // Stop error clears the pending E0.
        e0 = errCnt;
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h74, 1'b0, 1'b0);
        check("stop_err", 32'(errCnt - e0), 32'd1);
        send_frame(8'h75, 1'b0, 1'b1);
        check("stop_noext", 32'(keys), 32'h04);

        // Abandoned frame times out.
        e0 = errCnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2_data = 1'b1;
        for (int i = 0; i < 25000 && errCnt == e0; i++) @(negedge clk);
        check("to_err", 32'(errCnt - e0), 32'd1);
        delta = errCyc - lastFall;
        check("to_window", 32'(delta >= 19990 && delta <= 20040), 32'd1);
        send_frame(8'h23, 1'b0, 1'b1);
        check("d_make", 32'(keys), 32'h0C);

        // Opposing keys both held, then reset mid-frame.
        send_frame(8'h1D, 1'b0, 1'b1);
        send_frame(8'h1B, 1'b0, 1'b1);
        check("ws_held", 32'(keys), 32'h0F);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2_data = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_async", 32'(keys), 32'h00);
        repeat (4) @(negedge clk);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // Single-cycle ps2_clk glitches with data low must not start a frame.
        e0 = errCnt;
        v0 = validCnt;
        ps2_data = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ps2_clk = 1'b0;
            @(negedge clk);
            ps2_clk = 1'b1;
            repeat (5) @(negedge clk);
        end
        ps2_data = 1'b1;
        repeat (40) @(negedge clk);
        send_frame(8'h1B, 1'b0, 1'b1);
        check("s_after_rst", 32'(keys), 32'h02);
        check("glitch_valid", 32'(validCnt - v0), 32'd1);
        check("glitch_noerr", 32'(errCnt - e0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
